e1_tx_liu: RTL
==============

Name: e1_tx_liu

Overview:
- E1 line-side transmitter. Takes the serial NRZ bit stream from the framer and HDB3-encodes it (AMI selectable).
- Drives RZ half-bit pulses on two unipolar outputs, tx_hi (positive mark) and tx_lo (negative mark).
- Sits between the TX framer and the output IOB/LIU driver. It is the transmit counterpart of the E1 RX front-end.

Parameters:
- PULSE_LEN, 7, pulse width in clk cycles. Must be ≥ 1 and < the strobe period (15 cycles at 30.72 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- strobe  in  1  one-cycle bit tick, one per E1 bit period (2.048 MHz average)
- in_data  in  1  next NRZ bit from framer
- in_valid  in  1  in_data valid
- in_ready  out  1  combinational, equals strobe; bit consumed when in_valid & in_ready
- cfg_hdb3  in  1  1 = HDB3, 0 = plain AMI; sampled on strobe
- tx_hi  out  1  positive pulse to output IOB
- tx_lo  out  1  negative pulse to output IOB
- status_underflow  out  1  one-cycle pulse when strobe occurs with in_valid low

Behaviour:
- Symbol types: ZERO, MARK, B (bipolar-rule pulse), V (violation).
- Window: w0 (oldest) .. w3 (newest), 4 symbols.
- State: last_pol (polarity of last emitted pulse), parity (count of non-V pulses entering the window since last V, mod 2), pulse counter cnt.
- Reset values: window = all ZERO, last_pol = NEG (first pulse is positive), parity = 0, cnt = 0, tx_hi = tx_lo = 0, status_underflow = 0.
- Source bit per strobe: in_data if in_valid, else 1 (all-ones/AIS fill) and status_underflow = 1 in the same cycle.
- On strobe:
  - w0 goes to the output stage; shift w1→w0, w2→w1, w3→w2.
  - w3 = MARK if bit = 1, else ZERO.
  - MARK entering the window toggles parity.
- HDB3 substitution (cfg_hdb3 = 1): applies when the new bit = 0 and pre-shift w1, w2, w3 are all ZERO.
  - parity odd: new w3 = V; other entries unchanged (000V).
  - parity even: new w3 = V and post-shift w0 = B (B00V).
  - Parity is cleared to 0 in both cases.
  - A V already in the window is never matched, so consecutive substitutions are evaluated correctly.
- AMI (cfg_hdb3 = 0): no substitution; parity still tracked.
- Output polarity:
  - MARK and B take the opposite of last_pol; V takes the same as last_pol.
  - last_pol is updated to the emitted polarity. ZERO leaves last_pol unchanged.
- Pulse generation:
  - The cycle after a strobe that emits a pulse, the selected output goes high for exactly PULSE_LEN cycles, then low.
  - tx_hi and tx_lo are never high together; both are registered outputs.
- Latency: a bit accepted on strobe n appears as a pulse starting the cycle after strobe n+4.
- A strobe arriving while a pulse is active terminates that pulse and starts the new one the next cycle. The two outputs are still never both high.
- A change of cfg_hdb3 applies only to bits entering after the change. Symbols already in the window are emitted as stored.
- Reset mid-pulse: both outputs are low the cycle after rst is sampled, and all state returns to reset values.

Decomposition:
- Shared package e1_pkg holds:
  - symbol encoding (2-bit: ZERO = 0, MARK = 1, B = 2, V = 3)
  - polarity constants POS/NEG
  - E1 bit-rate constants
- One natural sub-module, e1_tx_pulse_gen: polarity plus symbol-type input, PULSE_LEN counter, tx_hi/tx_lo registers.
- The window/substitution logic stays in e1_tx_liu.

Test Plan:
- All ones, HDB3, 15-cycle strobe:
  - Expected: after 4 strobes of latency, pulses alternate hi, lo, hi, …
  - Each pulse is 7 cycles wide; never both high.
- All zeros from reset, HDB3:
  - Expected: B00V groups. First B = hi, V = hi; next B = lo, V = lo; repeating with alternating polarity.
- Input 1,0,0,0,0 from reset, HDB3:
  - Expected: MARK hi, then 000V with V = hi (parity odd).
  - Following zeros continue as B00V: B = lo, V = lo.
- All zeros, AMI: expect no pulses on either output after latency.
- in_valid held low for 3 strobes:
  - Expected: status_underflow pulses 3 times; three marks emitted with alternating polarity, 4 strobes later.
- rst asserted 3 cycles into a tx_hi pulse:
  - Expected: tx_hi low the next cycle.
  - Expected: next emitted mark after reset is hi, preceded by 4 strobes of silence.

Source files
------------

// File: rtl/e1_pkg.sv
// Shared definitions for the E1 transmit line interface: symbol encoding,
// pulse polarity and the nominal E1 bit-rate constants.
package e1_pkg;

   typedef enum logic [1:0] {
      SYM_ZERO = 2'd0,
      SYM_MARK = 2'd1,
      SYM_B    = 2'd2,
      SYM_V    = 2'd3
   } sym_t;

   typedef enum logic {
      NEG = 1'b0,
      POS = 1'b1
   } pol_t;

   localparam int unsigned E1_BIT_RATE_HZ = 2_048_000;
   localparam int unsigned SYS_CLK_HZ     = 30_720_000;
   localparam int unsigned STROBE_PERIOD  = SYS_CLK_HZ / E1_BIT_RATE_HZ;
   localparam int unsigned WIN_LEN        = 4;

   // Bipolar rule: marks and B pulses alternate, a V repeats the last polarity.
   function automatic pol_t pulse_pol(input sym_t sym, input pol_t last_pol);
      pol_t pol;
      case (sym)
         SYM_MARK, SYM_B: pol = (last_pol == POS) ? NEG : POS;
         SYM_V:           pol = last_pol;
         default:         pol = last_pol;
      endcase
      return pol;
   endfunction

endpackage

// File: rtl/e1_tx_pulse_gen.sv
// RZ pulse shaper: turns one emitted symbol per strobe into a PULSE_LEN-cycle
// pulse on tx_hi or tx_lo according to the requested polarity.
module e1_tx_pulse_gen
   import e1_pkg::*;
#(
   parameter int PULSE_LEN = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   input  sym_t sym,
   input  pol_t pol,
   output logic tx_hi,
   output logic tx_lo
);

   localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN + 1) : 1;

   logic [CNT_W-1:0] cnt;

   // A new strobe always wins over a pulse in flight, so the outputs swap
   // on a single edge and are never high together.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         tx_hi <= 1'b0;
         tx_lo <= 1'b0;
      end else if (strobe) begin
         if (sym != SYM_ZERO) begin
            tx_hi <= (pol == POS);
            tx_lo <= (pol == NEG);
            cnt   <= CNT_W'(PULSE_LEN - 1);
         end else begin
            tx_hi <= 1'b0;
            tx_lo <= 1'b0;
            cnt   <= '0;
         end
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end else begin
         tx_hi <= 1'b0;
         tx_lo <= 1'b0;
      end
   end

endmodule

// File: rtl/e1_tx_liu.sv
// E1 line-side transmitter: HDB3/AMI encoder over a four-symbol look-ahead
// window feeding the RZ pulse shaper.
module e1_tx_liu
   import e1_pkg::*;
#(
   parameter int PULSE_LEN = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   input  logic in_data,
   input  logic in_valid,
   output logic in_ready,
   input  logic cfg_hdb3,
   output logic tx_hi,
   output logic tx_lo,
   output logic status_underflow
);

   sym_t w0, w1, w2, w3;
   sym_t nxt_w0, nxt_w1, nxt_w2, nxt_w3;
   logic parity, nxt_parity;
   pol_t last_pol, emit_pol;
   logic src_bit, sub_match;

   assign in_ready         = strobe;
   assign src_bit          = in_valid ? in_data : 1'b1;
   assign status_underflow = strobe & ~in_valid & ~rst;

   // Four zeros in a row (three already queued plus the new bit) are replaced
   // by 000V or B00V so the V always alternates relative to the previous V.
   always_comb begin
      sub_match  = cfg_hdb3 && !src_bit &&
                   (w1 == SYM_ZERO) && (w2 == SYM_ZERO) && (w3 == SYM_ZERO);
      nxt_w0     = w1;
      nxt_w1     = w2;
      nxt_w2     = w3;
      nxt_w3     = src_bit ? SYM_MARK : SYM_ZERO;
      nxt_parity = parity ^ src_bit;
      if (sub_match) begin
         nxt_w3     = SYM_V;
         nxt_parity = 1'b0;
         if (!parity) nxt_w0 = SYM_B;
      end
      emit_pol = pulse_pol(w0, last_pol);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w0       <= SYM_ZERO;
         w1       <= SYM_ZERO;
         w2       <= SYM_ZERO;
         w3       <= SYM_ZERO;
         parity   <= 1'b0;
         last_pol <= NEG;
      end else if (strobe) begin
         w0     <= nxt_w0;
         w1     <= nxt_w1;
         w2     <= nxt_w2;
         w3     <= nxt_w3;
         parity <= nxt_parity;
         if (w0 != SYM_ZERO) last_pol <= emit_pol;
      end
   end

   e1_tx_pulse_gen #(
      .PULSE_LEN (PULSE_LEN)
   ) u_pulse_gen (
      .clk    (clk),
      .rst    (rst),
      .strobe (strobe),
      .sym    (w0),
      .pol    (emit_pol),
      .tx_hi  (tx_hi),
      .tx_lo  (tx_lo)
   );

endmodule
